// File: rtl/txuart_lite.sv
// txuart_lite: minimal 8N1 UART transmitter.
// One byte is accepted per write strobe while idle. The frame is one start
// bit (0), eight data bits LSB first and one stop bit (1). Each bit lasts
// CLOCKS_PER_BAUD cycles. o_uart_tx and o_busy come straight from flops,
// so there is no combinational path from i_wr to either output.
module txuart_lite #(
  parameter int unsigned CLOCKS_PER_BAUD = 868
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr,
  input  logic [7:0] i_data,
  output logic       o_uart_tx,
  output logic       o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // The counter counts down from CLOCKS_PER_BAUD-1 to 0, which gives
  // exactly CLOCKS_PER_BAUD cycles per bit. 24 bits covers the legal range
  // without wrapping.
  localparam logic [23:0] BAUD_RELOAD = 24'(CLOCKS_PER_BAUD - 1);

  state_t      state_q,    state_d;
  logic [23:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q,  bit_idx_d;
  logic [7:0]  shift_q,    shift_d;
  logic        tx_q,       tx_d;
  logic        busy_q,     busy_d;

  logic        baud_expired;

  assign baud_expired = (baud_cnt_q == 24'd0);

  // Next-state logic: accept a byte when idle, then advance one bit per baud expiry.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        // busy_q is always low in IDLE. It is tested anyway so that the
        // accept condition reads the same as the interface contract.
        if (i_wr && !busy_q) begin
          state_d    = START;
          shift_d    = i_data;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          baud_cnt_d = BAUD_RELOAD;
          bit_idx_d  = 3'd0;
        end
      end

      START: begin
        if (baud_expired) begin
          state_d    = DATA;
          baud_cnt_d = BAUD_RELOAD;
          bit_idx_d  = 3'd0;
          tx_d       = shift_q[0];
          shift_d    = {1'b0, shift_q[7:1]};
        end else begin
          baud_cnt_d = baud_cnt_q - 24'd1;
        end
      end

      DATA: begin
        if (baud_expired) begin
          baud_cnt_d = BAUD_RELOAD;
          if (bit_idx_q == 3'd7) begin
            // The last data bit is done, so drive the stop bit.
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_cnt_d = baud_cnt_q - 24'd1;
        end
      end

      STOP: begin
        if (baud_expired) begin
          // The full stop bit has elapsed. The line stays high and busy drops.
          state_d    = IDLE;
          busy_d     = 1'b0;
          tx_d       = 1'b1;
          baud_cnt_d = 24'd0;
          bit_idx_d  = 3'd0;
        end else begin
          baud_cnt_d = baud_cnt_q - 24'd1;
        end
      end

      default: begin
        state_d    = IDLE;
        busy_d     = 1'b0;
        tx_d       = 1'b1;
        baud_cnt_d = 24'd0;
        bit_idx_d  = 3'd0;
      end
    endcase
  end

  // State register: reset aborts any frame at once and returns the line high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= IDLE;
      baud_cnt_q <= 24'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_txuart_lite.sv
// Testbench for txuart_lite with CLOCKS_PER_BAUD=16.
// The stimulus pushes each accepted byte onto a queue. A line monitor decodes
// frames from o_uart_tx and compares them with the queue. A second monitor
// checks how long o_busy stays high for each frame.
module tb_txuart_lite;

  localparam int CPB = 16;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       wr   = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx;
  logic       busy;

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         gap_en   = 1'b0;

  txuart_lite #(.CLOCKS_PER_BAUD(CPB)) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_wr      (wr),
    .i_data    (data),
    .o_uart_tx (tx),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Waits (bounded) for the DUT to be idle, then issues one write strobe.
  // i_data is scrambled right after the accept edge.
  task automatic send(input logic [7:0] b, input bit chk_gap);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    if (busy !== 1'b0) begin
      n_checks++;
      $display("FAIL send_wait: busy=%b still set after %0d cycles, required 0", busy, t);
    end
    gap_en = chk_gap;
    wr     = 1'b1;
    data   = b;
    exp_q.push_back(b);
    @(posedge clk); #1;
    wr   = 1'b0;
    data = ~b;
  endtask

  // Line monitor: decodes each frame and checks it against the scoreboard.
  initial begin : line_mon
    int         idle;
    logic [9:0] bits;
    bit         ok;
    bit         abort;
    logic [7:0] want;
    idle = 0;
    forever begin
      @(negedge clk);
      while (!(tx === 1'b0 && rst === 1'b0)) begin
        if (tx === 1'b1) idle++;
        @(negedge clk);
      end
      if (gap_en) begin
        n_checks++;
        if (idle <= 2) n_pass++;
        else $display("FAIL gap: idle gap %0d cycles, required <= 2", idle);
      end
      ok    = 1'b1;
      abort = 1'b0;
      bits  = '0;
      for (int b = 0; b < 10; b++) begin
        for (int c = 0; c < CPB; c++) begin
          if (!(b == 0 && c == 0)) @(negedge clk);
          if (rst === 1'b1) abort = 1'b1;
          if (c == 0) bits[b] = tx;
          else if (tx !== bits[b]) ok = 1'b0;
        end
      end
      if (bits[0] !== 1'b0 || bits[9] !== 1'b1) ok = 1'b0;
      if (abort) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
        check("framing", {31'd0, ok}, 32'd1);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_frame: got byte %0h, required no frame", bits[8:1]);
        end else begin
          want = exp_q.pop_front();
          check("rx_byte", {24'd0, bits[8:1]}, {24'd0, want});
        end
      end
      idle = 0;
    end
  end

  // Busy monitor: every frame that is not aborted keeps o_busy high for 10*CPB cycles.
  initial begin : busy_mon
    int bcnt;
    bit babort;
    bcnt   = 0;
    babort = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) babort = 1'b1;
      if (busy === 1'b1) bcnt++;
      else begin
        if (bcnt > 0 && !babort) check("busy_len", bcnt, 10 * CPB);
        bcnt   = 0;
        babort = 1'b0;
      end
    end
  end

  // Directed stimulus sequence.
  initial begin : stim
    string msg;
    int    t;
    msg = "hello, world! It is a beautiful day!";

    // Reset held for 3 cycles, then idle.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_tx", {31'd0, tx}, 32'd1);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Single byte 0x55.
    send(8'h55, 1'b0);
    check("start_tx", {31'd0, tx}, 32'd0);
    check("start_busy", {31'd0, busy}, 32'd1);
    repeat (200) @(posedge clk);
    #1;

    // Write while busy: 0xFF must be ignored.
    send(8'h41, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    wr   = 1'b1;
    data = 8'hFF;
    @(posedge clk); #1;
    wr = 1'b0;
    repeat (200) @(posedge clk);
    #1;

    // Back-to-back string.
    for (int i = 0; i < msg.len(); i++) send(msg[i], i > 0);

    // Reset during data bit 3 of 0x00.
    send(8'h00, 1'b0);
    repeat (69) @(posedge clk);
    #1;
    check("pre_rst_tx", {31'd0, tx}, 32'd0);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_tx", {31'd0, tx}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    repeat (200) @(posedge clk);
    #1;
    send(8'hC3, 1'b0);

    // Data stability: send() scrambles i_data right after accept.
    send(8'hA5, 1'b0);

    // Drain the scoreboard within a bounded time.
    t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (20) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
